// File: rtl/pipe_ctrl.sv
// Pipeline control for the IF/ID/EX/MEM integer pipeline: stall/flush arbitration,
// exception capture and redirect. Optional IRQ sampling enabled by PIPE_CTRL_IRQ_EN.
module pipe_ctrl #(
  parameter logic [29:0] EXP_VECTOR = 30'h0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        if_busy,
  input  logic        ld_hazard,
  input  logic        mem_busy,
  input  logic        mem_en,
  input  logic [29:0] mem_pc,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [31:0] mem_wr_data,
  input  logic [2:0]  mem_exp_code,
  input  logic        irq,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc,
  output logic [29:0] epc,
  output logic [2:0]  exp_code,
  output logic        int_en
);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  state_t      r_state, w_state_nxt;
  logic [29:0] r_new_pc, r_epc;
  logic [2:0]  r_exp_code;
  logic        r_int_en, r_pre_int_en;
  logic        w_irq_take;
  logic        w_mem_ok, w_take_exp, w_take_ert, w_take_wr;
  logic [2:0]  w_cap_code;
  logic        w_unused_wr;

  assign w_unused_wr = ^mem_wr_data[31:1];

`ifdef PIPE_CTRL_IRQ_EN
  logic r_irq_s1, r_irq_s2;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_irq_s1 <= 1'b0;
      r_irq_s2 <= 1'b0;
    end else begin
      r_irq_s1 <= irq;
      r_irq_s2 <= r_irq_s1;
    end
  end

  assign w_irq_take = r_irq_s2 & r_int_en;
`else
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign w_irq_take   = 1'b0;
`endif

  // MEM events only count in RUN and once the bus access has completed.
  assign w_mem_ok   = (r_state == RUN) & mem_en & ~mem_busy;
  assign w_take_exp = w_mem_ok & ((mem_exp_code != 3'd0) | w_irq_take);
  assign w_take_ert = w_mem_ok & ~w_take_exp & (mem_ctrl_op == OP_EXRT);
  assign w_take_wr  = w_mem_ok & ~w_take_exp & (mem_ctrl_op == OP_WRCR);

  always_comb begin
    w_cap_code = mem_exp_code;
    if (mem_exp_code == 3'd7) w_cap_code = 3'd2;
    else if (mem_exp_code == 3'd0) w_cap_code = 3'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (w_take_exp || w_take_ert) w_state_nxt = REDIRECT;
        if (mem_busy) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_stall  = 1'b1;
          mem_stall = 1'b1;
        end else if (ld_hazard) begin
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
        end else if (if_busy) begin
          if_stall = 1'b1;
          id_flush = 1'b1;
        end
      end
      REDIRECT: begin
        w_state_nxt = RUN;
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        ex_flush    = 1'b1;
        mem_flush   = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
    // Outputs read as idle while reset is held, whatever the hazard inputs do.
    if (cpu_rst) begin
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_stall  = 1'b0;
      mem_stall = 1'b0;
      if_flush  = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      mem_flush = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state      <= RUN;
      r_new_pc     <= 30'h0;
      r_epc        <= 30'h0;
      r_exp_code   <= 3'd0;
      r_int_en     <= 1'b0;
      r_pre_int_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_exp) begin
        r_epc        <= mem_pc;
        r_exp_code   <= w_cap_code;
        r_pre_int_en <= r_int_en;
        r_int_en     <= 1'b0;
        r_new_pc     <= EXP_VECTOR;
      end else if (w_take_ert) begin
        r_new_pc <= r_epc;
        r_int_en <= r_pre_int_en;
      end else if (w_take_wr) begin
        r_int_en <= mem_wr_data[0];
      end
    end
  end

  assign new_pc   = r_new_pc;
  assign epc      = r_epc;
  assign exp_code = r_exp_code;
  assign int_en   = r_int_en;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; IRQ checks follow PIPE_CTRL_IRQ_EN.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam logic [29:0] VEC = 30'h0000_0040;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        if_busy, ld_hazard, mem_busy, mem_en, irq;
  logic [29:0] mem_pc;
  logic [1:0]  mem_ctrl_op;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_exp_code;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc, epc;
  logic [2:0]  exp_code;
  logic        int_en;

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl #(.EXP_VECTOR(VEC)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .if_busy(if_busy), .ld_hazard(ld_hazard),
    .mem_busy(mem_busy), .mem_en(mem_en), .mem_pc(mem_pc), .mem_ctrl_op(mem_ctrl_op),
    .mem_wr_data(mem_wr_data), .mem_exp_code(mem_exp_code), .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .epc(epc), .exp_code(exp_code), .int_en(int_en)
  );

  always #5 cpu_clk = ~cpu_clk;

  wire [3:0] stl = {if_stall, id_stall, ex_stall, mem_stall};
  wire [3:0] fls = {if_flush, id_flush, ex_flush, mem_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    if_busy = 0; ld_hazard = 0; mem_busy = 0; mem_en = 0; irq = 0;
    mem_pc = '0; mem_ctrl_op = 2'd0; mem_wr_data = '0; mem_exp_code = 3'd0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    cpu_rst = 1;
    ld_hazard = 1;
    settle();
    chk("rst_stall", {28'd0, stl}, 32'h0);
    chk("rst_flush", {28'd0, fls}, 32'h0);
    chk("rst_newpc", {2'd0, new_pc}, 32'h0);
    chk("rst_epc", {2'd0, epc}, 32'h0);
    chk("rst_code_inten", {28'd0, exp_code, int_en}, 32'h0);
    ld_hazard = 0;
    tick(); tick();
    cpu_rst = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_sf", {24'd0, stl, fls}, 32'h0);
    end

    // Overflow exception at 0x100, followed immediately by another faulting instruction.
    mem_en = 1; mem_pc = 30'h100; mem_exp_code = 3'd3;
    settle();
    chk("exc_n_flush", {28'd0, fls}, 32'h0);
    tick();
    mem_pc = 30'h200; mem_exp_code = 3'd5; ld_hazard = 1; mem_busy = 1;
    settle();
    chk("exc_n1_flush", {28'd0, fls}, 32'hF);
    chk("exc_n1_stall", {28'd0, stl}, 32'h0);
    chk("exc_n1_newpc", {2'd0, new_pc}, {2'd0, VEC});
    chk("exc_n1_epc", {2'd0, epc}, 32'h100);
    chk("exc_n1_code", {29'd0, exp_code}, 32'd3);
    chk("exc_n1_inten", {31'd0, int_en}, 32'd0);
    mem_busy = 0; ld_hazard = 0;
    tick();
    idle();
    settle();
    chk("exc_n2_flush", {28'd0, fls}, 32'h0);
    chk("b2b_epc", {2'd0, epc}, 32'h100);
    chk("b2b_code", {29'd0, exp_code}, 32'd3);

    // WRCR blocked while busy, then taken.
    mem_en = 1; mem_ctrl_op = 2'd1; mem_wr_data = 32'h1; mem_busy = 1;
    tick();
    chk("wrcr_busy_inten", {31'd0, int_en}, 32'd0);
    mem_busy = 0;
    tick();
    chk("wrcr_inten", {31'd0, int_en}, 32'd1);

    // Reserved code 7 maps to undef, then EXRT restores state.
    mem_ctrl_op = 2'd0; mem_pc = 30'h155; mem_exp_code = 3'd7;
    tick();
    idle();
    settle();
    chk("c7_code", {29'd0, exp_code}, 32'd2);
    chk("c7_epc", {2'd0, epc}, 32'h155);
    chk("c7_inten", {31'd0, int_en}, 32'd0);
    tick();
    mem_en = 1; mem_ctrl_op = 2'd2; mem_pc = 30'h3FF;
    tick();
    idle();
    settle();
    chk("exrt_flush", {28'd0, fls}, 32'hF);
    chk("exrt_newpc", {2'd0, new_pc}, 32'h155);
    chk("exrt_inten", {31'd0, int_en}, 32'd1);
    tick();
    chk("exrt_flush_end", {28'd0, fls}, 32'h0);

    // Busy hides exception; it is taken once busy falls.
    mem_busy = 1; ld_hazard = 1; mem_en = 1; mem_pc = 30'h2A0; mem_exp_code = 3'd4;
    settle();
    chk("busy_stall", {28'd0, stl}, 32'hF);
    chk("busy_flush", {28'd0, fls}, 32'h0);
    tick();
    chk("busy_hold_flush", {28'd0, fls}, 32'h0);
    chk("busy_hold_epc", {2'd0, epc}, 32'h155);
    mem_busy = 0;
    settle();
    chk("busy_drop_stall", {28'd0, stl}, 32'hC);
    chk("busy_drop_flush", {28'd0, fls}, 32'h2);
    tick();
    idle();
    settle();
    chk("busy_exc_flush", {28'd0, fls}, 32'hF);
    chk("busy_exc_epc", {2'd0, epc}, 32'h2A0);
    chk("busy_exc_code", {29'd0, exp_code}, 32'd4);
    tick();

    ld_hazard = 1;
    settle();
    chk("ld_stall", {28'd0, stl}, 32'hC);
    chk("ld_flush", {28'd0, fls}, 32'h2);
    ld_hazard = 0; if_busy = 1;
    settle();
    chk("ifb_stall", {28'd0, stl}, 32'h8);
    chk("ifb_flush", {28'd0, fls}, 32'h4);
    if_busy = 0;

    // Reset during the redirect cycle cuts the flush.
    mem_en = 1; mem_pc = 30'h77; mem_exp_code = 3'd6;
    tick();
    idle();
    settle();
    chk("rr_flush_pre", {28'd0, fls}, 32'hF);
    cpu_rst = 1;
    settle();
    chk("rr_flush_cut", {28'd0, fls}, 32'h0);
    chk("rr_epc", {2'd0, epc}, 32'h0);
    tick();
    cpu_rst = 0;
    tick();
    chk("rr_after", {24'd0, stl, fls}, 32'h0);

    // IRQ: enable interrupts, then raise irq with a clean MEM instruction.
    mem_en = 1; mem_ctrl_op = 2'd1; mem_wr_data = 32'h1;
    tick();
    mem_ctrl_op = 2'd0; mem_pc = 30'h1A4; irq = 1;
    tick();
    chk("irq_t1", {28'd0, fls}, 32'h0);
    tick();
    chk("irq_t2", {28'd0, fls}, 32'h0);
    tick();
`ifdef PIPE_CTRL_IRQ_EN
    chk("irq_t3_flush", {28'd0, fls}, 32'hF);
    chk("irq_code", {29'd0, exp_code}, 32'd1);
    chk("irq_epc", {2'd0, epc}, 32'h1A4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("irq_masked", {28'd0, fls}, 32'h0);
    end
`else
    chk("irq_ignored", {28'd0, fls}, 32'h0);
    chk("irq_ign_inten", {31'd0, int_en}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("irq_ign_run", {28'd0, fls}, 32'h0);
    end
`endif
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
